fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  START_ADDRESS  32'h80020000  PC value after reset
  ADDRESS_SIZE   32            address width
  DATA_SIZE      32            instruction width
  FIFO_DEPTH     4             instruction buffer entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk           in   1   single clock, all state on rising edge
  rst           in   1   synchronous reset, active-high
  redirect_en   in   1   branch/jump redirect request
  redirect_pc   in   32  redirect target
  insn_ready    in   1   decode accepts head instruction this cycle
  insn_valid    out  1   head instruction valid
  insn          out  32  head instruction word
  insn_pc       out  32  PC of head instruction
  mem_addr      out  32  byte address to memory
  mem_en        out  1   memory read request
  mem_wren      out  1   memory write enable, tied 0
  mem_acc_size  out  2   access size, tied 2'b00 (single word)
  mem_d_out     in   32  read data from memory
  mem_busy      in   1   memory cannot accept a request
REQ-003 Ports SHALL use big-endian bit numbering [0:N-1], bit 0 MSB.

Function
REQ-004 Fetch PC SHALL be a 32-bit register; each issued request uses mem_addr = pc, then pc <= pc + 4, wrapping modulo 2^32.
REQ-005 mem_en, mem_addr SHALL be registered outputs; a request is "issued" in every cycle where mem_en=1.
REQ-006 Issue SHALL occur in cycle N+1 (mem_en=1) when, at rising edge ending cycle N: rst=0, redirect_en=0, mem_busy=0, and (fifo_count + inflight) < FIFO_DEPTH.
REQ-007 Read data SHALL be sampled from mem_d_out at the rising edge ending the issue cycle (one-cycle latency) and pushed with its PC into the FIFO, unless discarded per REQ-011.
REQ-008 At most one request SHALL be in flight; inflight is 1 for exactly the cycle mem_en=1.
REQ-009 FIFO SHALL be FIFO_DEPTH entries of {pc, insn}; head drives insn/insn_pc; insn_valid = (fifo_count != 0).
REQ-010 Pop SHALL occur when insn_valid && insn_ready; simultaneous push and pop SHALL leave fifo_count unchanged; fifo_count SHALL never exceed FIFO_DEPTH nor underflow.
REQ-011 redirect_en=1 at a rising edge SHALL: empty the FIFO, discard any in-flight response, set pc <= {redirect_pc[0:29], 2'b00}, force mem_en=0 for the following cycle; issue resumes the cycle after.
REQ-012 redirect_en SHALL take priority over push, pop and issue in the same cycle; a pop concurrent with redirect is lost (decode must not count it).
REQ-013 mem_busy=1 SHALL suppress new issue only; an already-issued response SHALL still be captured.
REQ-014 insn_ready=0 with a full FIFO SHALL stall issue with pc held; no instruction SHALL be dropped or duplicated.
REQ-015 mem_wren SHALL be constant 0 and mem_acc_size constant 2'b00.

Reset
REQ-016 rst=1 at a rising edge SHALL set pc=START_ADDRESS, fifo_count=0, inflight=0, mem_en=0, mem_addr=START_ADDRESS, insn_valid=0, insn=0, insn_pc=0.
REQ-017 rst asserted mid-fetch SHALL discard the in-flight response; first post-reset issue SHALL occur the cycle after rst deasserts, at START_ADDRESS.
REQ-018 rst SHALL override redirect_en.

Verification
REQ-019 Reset release, insn_ready=1, memory returns addr-derived words -> mem_addr 0x80020000, 0x80020004, 0x80020008 in consecutive cycles; insn_pc matches each, no gaps after first fill.
REQ-020 insn_ready=0 for 10 cycles -> exactly 4 entries buffered, mem_en=0 thereafter, pc=0x80020010; release -> 4 pops in order, fetch resumes at 0x80020010.
REQ-021 redirect_en=1, redirect_pc=0x80020103 while request in flight and FIFO holds 2 -> insn_valid=0 next cycle, in-flight word discarded, next mem_addr=0x80020100.
REQ-022 mem_busy=1 for 3 cycles during streaming -> no issue those cycles, pending response captured, no PC skipped.
REQ-023 Full FIFO with simultaneous pop and push -> fifo_count stays 4, order preserved.
REQ-024 pc=0xFFFFFFFC issue -> next mem_addr=0x00000000; rst mid-stream -> outputs per REQ-016, restart at 0x80020000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read per cycle into a small {pc, insn} queue.
// Read data lands one cycle after issue; issue stalls on mem_busy or when queue + in-flight is full.
module fetch_unit #(
    parameter logic [31:0] START_ADDRESS = 32'h80020000,
    parameter int          ADDRESS_SIZE  = 32,
    parameter int          DATA_SIZE     = 32,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_en,
    input  logic [0:ADDRESS_SIZE-1] redirect_pc,
    input  logic                    insn_ready,
    output logic                    insn_valid,
    output logic [0:DATA_SIZE-1]    insn,
    output logic [0:ADDRESS_SIZE-1] insn_pc,
    output logic [0:ADDRESS_SIZE-1] mem_addr,
    output logic                    mem_en,
    output logic                    mem_wren,
    output logic [0:1]              mem_acc_size,
    input  logic [0:DATA_SIZE-1]    mem_d_out,
    input  logic                    mem_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:ADDRESS_SIZE-1] START_PC = ADDRESS_SIZE'(START_ADDRESS);

    logic [0:ADDRESS_SIZE-1] pc_q, pc_d;
    logic [0:ADDRESS_SIZE-1] mem_addr_q, mem_addr_d;
    logic                    mem_en_q, mem_en_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [0:ADDRESS_SIZE-1] fifo_pc_q   [FIFO_DEPTH];
    logic [0:DATA_SIZE-1]    fifo_insn_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             can_issue;
    logic [CNT_W-1:0] occupancy;

    assign insn_valid   = (count_q != '0);
    assign insn         = insn_valid ? fifo_insn_q[rd_ptr_q] : '0;
    assign insn_pc      = insn_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    assign mem_addr     = mem_addr_q;
    assign mem_en       = mem_en_q;
    assign mem_wren     = 1'b0;
    assign mem_acc_size = 2'b00;

    // The in-flight word already owns a slot, so it is counted against capacity.
    assign occupancy = count_q + CNT_W'(mem_en_q);
    assign push      = mem_en_q && !redirect_en;
    assign pop       = insn_valid && insn_ready && !redirect_en;
    assign can_issue = !redirect_en && !mem_busy && (occupancy < CNT_W'(FIFO_DEPTH));

    always_comb begin
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_en_d   = 1'b0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (redirect_en) begin
            pc_d     = redirect_pc & ~ADDRESS_SIZE'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (can_issue) begin
            mem_en_d   = 1'b1;
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDRESS_SIZE'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= START_PC;
            mem_addr_q <= START_PC;
            mem_en_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_en_q   <= mem_en_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
            fifo_insn_q[wr_ptr_q] <= mem_d_out;
        end
    end

endmodule
